// File: rtl/entropy_health.sv
// Online health tests (repetition-count and adaptive-proportion) for a raw 8-bit
// noise source. Samples are forwarded only in RUN, after a clean startup sequence.
module entropy_health #(
    parameter int RCT_CUTOFF      = 8,
    parameter int APT_WINDOW      = 64,
    parameter int APT_CUTOFF      = 24,
    parameter int STARTUP_SAMPLES = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic [7:0] raw_i,
    input  logic       raw_valid_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic [1:0] error_o
);

    localparam int REP_W = $clog2(RCT_CUTOFF) + 1;
    localparam int APT_W = $clog2(APT_CUTOFF) + 1;
    localparam int WIN_W = $clog2(APT_WINDOW) + 1;
    localparam int SU_W  = $clog2(STARTUP_SAMPLES) + 1;

    localparam logic [REP_W-1:0] REP_MAX = REP_W'(RCT_CUTOFF);
    localparam logic [APT_W-1:0] APT_MAX = APT_W'(APT_CUTOFF);
    localparam logic [WIN_W-1:0] WIN_LEN = WIN_W'(APT_WINDOW);
    localparam logic [SU_W-1:0]  SU_LEN  = SU_W'(STARTUP_SAMPLES);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_PENDING = 2'b01;
    localparam logic [1:0] ERR_WAIT    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STARTUP,
        ST_RUN,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         last_q, last_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [7:0]         ref_q, ref_d;
    logic [APT_W-1:0]   match_q, match_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [SU_W-1:0]    su_q, su_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic [1:0]         err_q, err_d;

    // Candidate test state if the current sample were committed
    logic               accept;
    logic [REP_W-1:0]   rep_upd;
    logic [7:0]         ref_upd;
    logic [APT_W-1:0]   match_upd;
    logic [WIN_W-1:0]   win_inc;
    logic [WIN_W-1:0]   win_upd;
    logic               win_end;
    logic               rct_fail;
    logic               apt_fail;
    logic [SU_W-1:0]    su_inc;

    always_comb begin
        accept = raw_valid_i && enable_i;

        // rep_q == 0 means no previous sample since the tests were last cleared
        if ((rep_q != '0) && (raw_i == last_q)) begin
            rep_upd = (rep_q >= REP_MAX) ? rep_q : rep_q + 1'b1;
        end else begin
            rep_upd = REP_W'(1);
        end
        rct_fail = (rep_upd >= REP_MAX);

        if (win_q == '0) begin
            ref_upd   = raw_i;
            match_upd = APT_W'(1);
        end else begin
            ref_upd   = ref_q;
            match_upd = ((raw_i == ref_q) && (match_q < APT_MAX)) ? match_q + 1'b1 : match_q;
        end
        apt_fail = (match_upd >= APT_MAX);
        win_inc  = win_q + 1'b1;
        win_end  = (win_inc == WIN_LEN);
        win_upd  = win_end ? '0 : win_inc;

        su_inc = su_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        rep_d   = rep_q;
        ref_d   = ref_q;
        match_d = match_q;
        win_d   = win_q;
        su_d    = su_q;
        data_d  = data_q;
        valid_d = 1'b0;

        if (!enable_i) begin
            state_d = ST_IDLE;
            last_d  = '0;
            rep_d   = '0;
            ref_d   = '0;
            match_d = '0;
            win_d   = '0;
            su_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_STARTUP;
                end

                ST_STARTUP: begin
                    if (accept) begin
                        if (rct_fail || apt_fail) begin
                            last_d  = '0;
                            rep_d   = '0;
                            ref_d   = '0;
                            match_d = '0;
                            win_d   = '0;
                            su_d    = '0;
                        end else begin
                            last_d  = raw_i;
                            rep_d   = rep_upd;
                            ref_d   = ref_upd;
                            match_d = match_upd;
                            win_d   = win_upd;
                            if (su_inc == SU_LEN) begin
                                state_d = ST_RUN;
                                su_d    = '0;
                            end else begin
                                su_d = su_inc;
                            end
                        end
                    end
                end

                ST_RUN: begin
                    if (accept) begin
                        if (rct_fail || apt_fail) begin
                            state_d = rct_fail ? ST_STARTUP : ST_WAIT;
                            last_d  = '0;
                            rep_d   = '0;
                            ref_d   = '0;
                            match_d = '0;
                            win_d   = '0;
                            su_d    = '0;
                        end else begin
                            last_d  = raw_i;
                            rep_d   = rep_upd;
                            ref_d   = ref_upd;
                            match_d = match_upd;
                            win_d   = win_upd;
                            data_d  = raw_i;
                            valid_d = 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (accept) begin
                        if (rct_fail) begin
                            state_d = ST_STARTUP;
                            last_d  = '0;
                            rep_d   = '0;
                            ref_d   = '0;
                            match_d = '0;
                            win_d   = '0;
                            su_d    = '0;
                        end else if (apt_fail) begin
                            // Repetition history survives; only the window restarts
                            last_d  = raw_i;
                            rep_d   = rep_upd;
                            ref_d   = '0;
                            match_d = '0;
                            win_d   = '0;
                        end else begin
                            last_d  = raw_i;
                            rep_d   = rep_upd;
                            ref_d   = ref_upd;
                            match_d = match_upd;
                            win_d   = win_upd;
                            if (win_end) begin
                                state_d = ST_RUN;
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        unique case (state_d)
            ST_RUN:  err_d = ERR_OK;
            ST_WAIT: err_d = ERR_WAIT;
            default: err_d = ERR_PENDING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= '0;
            rep_q   <= '0;
            ref_q   <= '0;
            match_q <= '0;
            win_q   <= '0;
            su_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= ERR_PENDING;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rep_q   <= rep_d;
            ref_q   <= ref_d;
            match_q <= match_d;
            win_q   <= win_d;
            su_q    <= su_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign error_o = err_q;

endmodule
